// File: rtl/dm_arbiter.sv
// dm_arbiter: two-requester data-memory arbiter with size/alignment handling,
// lane steering for stores and loads, and a bounded wait for the memory ack.
module dm_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [1:0]  r0_sel,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_gnt,
    output logic        r0_done,
    output logic        r0_err,
    output logic [31:0] r0_rdata,

    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [1:0]  r1_sel,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_gnt,
    output logic        r1_done,
    output logic        r1_err,
    output logic [31:0] r1_rdata,

    output logic        m_req,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_byteen,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] SEL_WORD = 2'b00;
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic               last;
    logic               owner;
    logic               mask_vld;
    logic               mask_id;
    logic [CNT_W-1:0]   cnt;
    logic               bad_q;
    logic               we_q;
    logic [1:0]         sel_q;
    logic [1:0]         off_q;
    logic [31:0]        rdata_q;

    // Arbitration result and the winner's payload
    logic               elig0;
    logic               elig1;
    logic               any_req;
    logic               pick;
    logic               pick_we;
    logic [1:0]         pick_sel;
    logic [31:0]        pick_addr;
    logic [31:0]        pick_wdata;

    // Lane steering for the winner and load extraction for the owner
    logic               bad;
    logic [3:0]         lane_be;
    logic [31:0]        lane_wdata;
    logic [31:0]        load_data;

    assign r0_rdata = rdata_q;
    assign r1_rdata = rdata_q;

    // Round-robin pick with the just-served requester masked for one IDLE cycle
    always_comb begin
        elig0   = r0_req && !(mask_vld && (mask_id == 1'b0));
        elig1   = r1_req && !(mask_vld && (mask_id == 1'b1));
        any_req = elig0 || elig1;
        pick    = elig1;
        if (elig0 && elig1) begin
            pick = ~last;
        end
        pick_we    = pick ? r1_we    : r0_we;
        pick_sel   = pick ? r1_sel   : r0_sel;
        pick_addr  = pick ? r1_addr  : r0_addr;
        pick_wdata = pick ? r1_wdata : r0_wdata;
    end

    // Legality check, byte enables and store-data placement for the winner
    always_comb begin
        bad        = 1'b0;
        lane_be    = 4'b0000;
        lane_wdata = 32'h0;
        case (pick_sel)
            SEL_WORD: begin
                bad        = (pick_addr[1:0] != 2'b00);
                lane_be    = 4'b1111;
                lane_wdata = pick_wdata;
            end
            SEL_HALF: begin
                bad        = pick_addr[0];
                lane_be    = pick_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = pick_addr[1] ? {pick_wdata[15:0], 16'h0}
                                          : {16'h0, pick_wdata[15:0]};
            end
            SEL_BYTE: begin
                case (pick_addr[1:0])
                    2'b00:   begin lane_be = 4'b0001; lane_wdata = {24'h0, pick_wdata[7:0]};        end
                    2'b01:   begin lane_be = 4'b0010; lane_wdata = {16'h0, pick_wdata[7:0], 8'h0};  end
                    2'b10:   begin lane_be = 4'b0100; lane_wdata = {8'h0, pick_wdata[7:0], 16'h0};  end
                    default: begin lane_be = 4'b1000; lane_wdata = {pick_wdata[7:0], 24'h0};        end
                endcase
            end
            default: begin
                bad = 1'b1;
            end
        endcase
    end

    // Right-align and zero-extend the addressed lane(s) of the memory word
    always_comb begin
        load_data = 32'h0;
        case (sel_q)
            SEL_WORD: load_data = m_rdata;
            SEL_HALF: load_data = off_q[1] ? {16'h0, m_rdata[31:16]} : {16'h0, m_rdata[15:0]};
            SEL_BYTE: begin
                case (off_q)
                    2'b00:   load_data = {24'h0, m_rdata[7:0]};
                    2'b01:   load_data = {24'h0, m_rdata[15:8]};
                    2'b10:   load_data = {24'h0, m_rdata[23:16]};
                    default: load_data = {24'h0, m_rdata[31:24]};
                endcase
            end
            default: load_data = 32'h0;
        endcase
    end

    // Control FSM with all handshake outputs registered
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            owner    <= 1'b0;
            mask_vld <= 1'b0;
            mask_id  <= 1'b0;
            cnt      <= '0;
            bad_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= 2'b00;
            off_q    <= 2'b00;
            rdata_q  <= 32'h0;
            r0_gnt   <= 1'b0;
            r1_gnt   <= 1'b0;
            r0_done  <= 1'b0;
            r1_done  <= 1'b0;
            r0_err   <= 1'b0;
            r1_err   <= 1'b0;
            m_req    <= 1'b0;
            m_addr   <= 32'h0;
            m_wdata  <= 32'h0;
            m_byteen <= 4'b0000;
        end else begin
            r0_gnt  <= 1'b0;
            r1_gnt  <= 1'b0;
            r0_done <= 1'b0;
            r1_done <= 1'b0;
            r0_err  <= 1'b0;
            r1_err  <= 1'b0;
            case (state)
                IDLE: begin
                    mask_vld <= 1'b0;
                    if (any_req) begin
                        owner    <= pick;
                        last     <= pick;
                        r0_gnt   <= (pick == 1'b0);
                        r1_gnt   <= (pick == 1'b1);
                        bad_q    <= bad;
                        we_q     <= pick_we;
                        sel_q    <= pick_sel;
                        off_q    <= pick_addr[1:0];
                        m_addr   <= {pick_addr[31:2], 2'b00};
                        m_wdata  <= pick_we ? lane_wdata : 32'h0;
                        m_byteen <= pick_we ? lane_be : 4'b0000;
                        m_req    <= !bad;
                        cnt      <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (bad_q) begin
                        // Rejected request: finish with an error, memory untouched
                        r0_done <= (owner == 1'b0);
                        r1_done <= (owner == 1'b1);
                        r0_err  <= (owner == 1'b0);
                        r1_err  <= (owner == 1'b1);
                        rdata_q <= 32'h0;
                        state   <= DONE;
                    end else if (m_ack) begin
                        m_req   <= 1'b0;
                        r0_done <= (owner == 1'b0);
                        r1_done <= (owner == 1'b1);
                        rdata_q <= we_q ? 32'h0 : load_data;
                        state   <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Memory never answered: abort the access
                        m_req   <= 1'b0;
                        r0_done <= (owner == 1'b0);
                        r1_done <= (owner == 1'b1);
                        r0_err  <= (owner == 1'b0);
                        r1_err  <= (owner == 1'b1);
                        rdata_q <= 32'h0;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    mask_vld <= 1'b1;
                    mask_id  <= owner;
                    state    <= IDLE;
                end
                default: begin
                    m_req <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: randomized and directed stimulus for dm_arbiter, checked by a
// scoreboard fed from a size/offset arithmetic reference model.
module tb_dm_arbiter;

    localparam int unsigned TIMEOUT = 16;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [1:0]  r0_sel, r1_sel;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic        r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic        m_req, m_ack;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_byteen;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        we;
        logic [1:0]  sel;
        logic [31:0] addr;
        int          d;
        logic [31:0] word;
        logic        bad;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_err;
        logic [31:0] e_rdata;
        int          e_mreq;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];
    int   gnt_log[$];

    dm_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_sel(r0_sel), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_sel(r1_sel), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_byteen(m_byteen),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: expected bus image and response from size/offset arithmetic
    function automatic txn_t make_txn(input logic we, input logic [1:0] sel, input logic [31:0] addr,
                                      input logic [31:0] wdata, input int d, input logic [31:0] word);
        txn_t t;
        int size;
        int off;
        logic [31:0] mask;
        t.we = we; t.sel = sel; t.addr = addr; t.d = d; t.word = word;
        off  = int'(addr[1:0]);
        size = (sel == 2'd0) ? 4 : (sel == 2'd1) ? 2 : 1;
        mask = (size == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * size)) - 1);
        t.bad     = (sel == 2'd3) || ((off % size) != 0);
        t.e_addr  = (addr / 4) * 4;
        t.e_be    = we ? 4'(((1 << size) - 1) << off) : 4'b0000;
        t.e_wdata = we ? ((wdata & mask) << (8 * off)) : 32'h0;
        if (t.bad) begin
            t.e_err = 1'b1; t.e_rdata = 32'h0; t.e_mreq = 0;
        end else if (d >= int'(TIMEOUT)) begin
            t.e_err = 1'b1; t.e_rdata = 32'h0; t.e_mreq = int'(TIMEOUT);
        end else begin
            t.e_err = 1'b0; t.e_mreq = d + 1;
            t.e_rdata = we ? 32'h0 : ((word >> (8 * off)) & mask);
        end
        return t;
    endfunction

    function automatic logic gnt_of(input int id);
        return (id == 0) ? r0_gnt : r1_gnt;
    endfunction

    function automatic logic done_of(input int id);
        return (id == 0) ? r0_done : r1_done;
    endfunction

    task automatic set_req(input int id, input logic v);
        if (id == 0) r0_req = v; else r1_req = v;
    endtask

    task automatic drive_payload(input int id, input logic we, input logic [1:0] sel,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (id == 0) begin r0_we = we; r0_sel = sel; r0_addr = addr; r0_wdata = wdata; end
        else         begin r1_we = we; r1_sel = sel; r1_addr = addr; r1_wdata = wdata; end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Push the expectation, raise req, garble the payload after grant, wait for done
    task automatic issue(input int id, input logic we, input logic [1:0] sel, input logic [31:0] addr,
                         input logic [31:0] wdata, input int d, input logic [31:0] word,
                         output int gnt_lat, output int done_lat);
        txn_t t;
        int n;
        t = make_txn(we, sel, addr, wdata, d, word);
        if (id == 0) q0.push_back(t); else q1.push_back(t);
        drive_payload(id, we, sel, addr, wdata);
        set_req(id, 1'b1);
        gnt_lat = -1; done_lat = -1; n = 0;
        while (n < 100 && done_lat < 0) begin
            @(posedge clk);
            #1;
            n++;
            if (gnt_of(id) && gnt_lat < 0) begin
                gnt_lat = n;
                drive_payload(id, 1'($urandom), 2'($urandom), $urandom, $urandom);
            end
            if (done_of(id)) done_lat = n;
        end
        if (done_lat < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_wait r%0d: no done after %0d cycles, required within 100", id, n);
        end
    endtask

    task automatic rand_stream(input int id, input int count);
        int gl, dl, r, size, d;
        logic [1:0] s;
        logic [31:0] a;
        for (int i = 0; i < count; i++) begin
            r = int'($urandom_range(0, 15));
            s = (r < 6) ? 2'd0 : (r < 11) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
            size = (s == 2'd0) ? 4 : (s == 2'd1) ? 2 : 1;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(size - 1);
            d = ($urandom_range(0, 15) == 0) ? NEVER : int'($urandom_range(0, 4));
            issue(id, 1'($urandom), s, a, $urandom, d, $urandom, gl, dl);
            if ($urandom_range(0, 1) == 1) begin
                set_req(id, 1'b0);
                idle(int'($urandom_range(1, 3)));
            end
        end
        set_req(id, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"},    32'({r0_gnt, r1_gnt}), 32'h0);
        chk({tag, "_done"},   32'({r0_done, r1_done, r0_err, r1_err}), 32'h0);
        chk({tag, "_rdata"},  r0_rdata | r1_rdata, 32'h0);
        chk({tag, "_m_req"},  32'(m_req), 32'h0);
        chk({tag, "_m_addr"}, m_addr, 32'h0);
        chk({tag, "_m_wdata"}, m_wdata, 32'h0);
        chk({tag, "_m_byteen"}, 32'(m_byteen), 32'h0);
    endtask

    // Monitor: arbitration rule, bus image, memory responder and done scoreboard
    initial begin : monitor
        txn_t t;
        int mreq_cnt = 0;
        int cur = 0;
        int model_last = 1;
        int win, ex, id_p, id_p2;
        logic e0, e1, p_req0, p_req1, dn_p, dn_p2;
        id_p = 0; id_p2 = 0; p_req0 = 0; p_req1 = 0; dn_p = 0; dn_p2 = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                model_last = 1; mreq_cnt = 0; dn_p = 0; dn_p2 = 0;
                p_req0 = 0; p_req1 = 0; m_ack = 1'b0; m_rdata = 32'h0;
            end else begin
                if (r0_gnt || r1_gnt) begin
                    win = r1_gnt ? 1 : 0;
                    e0  = p_req0 && !(dn_p2 && id_p2 == 0);
                    e1  = p_req1 && !(dn_p2 && id_p2 == 1);
                    ex  = (e0 && e1) ? (1 - model_last) : e1 ? 1 : e0 ? 0 : 2;
                    chk("grant_winner", 32'(win), 32'(ex));
                    chk("single_grant", 32'(r0_gnt & r1_gnt), 32'h0);
                    gnt_log.push_back(win);
                    model_last = win; cur = win; mreq_cnt = 0;
                    if (win == 0 ? q0.size() > 0 : q1.size() > 0) begin
                        t = (win == 0) ? q0[0] : q1[0];
                        chk("m_req_at_grant", 32'(m_req), 32'(!t.bad));
                    end
                end
                if (m_req) begin
                    mreq_cnt++;
                    if (cur == 0 ? q0.size() > 0 : q1.size() > 0) begin
                        t = (cur == 0) ? q0[0] : q1[0];
                        chk("m_addr", m_addr, t.e_addr);
                        chk("m_byteen", 32'(m_byteen), 32'(t.e_be));
                        if (t.we) chk("m_wdata", m_wdata, t.e_wdata);
                        if (mreq_cnt - 1 == t.d) begin
                            m_ack = 1'b1; m_rdata = t.word;
                        end else begin
                            m_ack = 1'b0; m_rdata = $urandom;
                        end
                    end else begin
                        m_ack = 1'b0; m_rdata = $urandom;
                    end
                end else begin
                    m_ack = ($urandom_range(0, 3) == 0); m_rdata = $urandom;
                end
                for (int id = 0; id < 2; id++) begin
                    if (done_of(id)) begin
                        if (id == 0 ? q0.size() == 0 : q1.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_done r%0d: got done, expected none", id);
                        end else begin
                            t = (id == 0) ? q0.pop_front() : q1.pop_front();
                            chk("done_owner", 32'(id), 32'(cur));
                            chk("err", 32'(id == 0 ? r0_err : r1_err), 32'(t.e_err));
                            if (!t.we || t.e_err) chk("rdata", id == 0 ? r0_rdata : r1_rdata, t.e_rdata);
                            chk("m_req_cycles", 32'(mreq_cnt), 32'(t.e_mreq));
                        end
                    end
                end
                dn_p2 = dn_p; id_p2 = id_p;
                dn_p = r0_done || r1_done; id_p = r1_done ? 1 : 0;
                p_req0 = r0_req; p_req1 = r1_req;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int gl, dl;
        reset = 1'b0;
        r0_req = 1'b0; r1_req = 1'b0;
        drive_payload(0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive_payload(1, 1'b0, 2'b00, 32'h0, 32'h0);
        m_ack = 1'b0; m_rdata = 32'h0;
        idle(2);
        check_reset_outputs("reset");
        reset = 1'b1;
        idle(2);

        // r0 byte store at 0x13, ack on the third m_req cycle
        issue(0, 1'b1, 2'b10, 32'h13, 32'hAB, 2, 32'h0, gl, dl);
        chk("b_store_gnt_lat", 32'(gl), 32'd1);
        chk("b_store_done_lat", 32'(dl), 32'd4);
        set_req(0, 1'b0);
        idle(3);

        // r1 half load at 0x22, immediate ack: minimum latency
        issue(1, 1'b0, 2'b01, 32'h22, 32'h0, 0, 32'h8765_4321, gl, dl);
        chk("h_load_gnt_lat", 32'(gl), 32'd1);
        chk("h_load_done_lat", 32'(dl), 32'd2);
        chk("h_load_rdata", r1_rdata, 32'h0000_8765);
        set_req(1, 1'b0);
        idle(3);

        // r0 misaligned word: error right after grant
        issue(0, 1'b0, 2'b00, 32'h06, 32'h0, 0, 32'h0, gl, dl);
        chk("misalign_gnt_lat", 32'(gl), 32'd1);
        chk("misalign_done_lat", 32'(dl), 32'd2);
        set_req(0, 1'b0);
        idle(3);

        // r1 load with no ack at all: timeout abort
        issue(1, 1'b0, 2'b00, 32'h100, 32'h0, NEVER, 32'h0, gl, dl);
        chk("timeout_done_lat", 32'(dl), 32'(TIMEOUT + 1));
        set_req(1, 1'b0);
        idle(3);

        // Both requesters from reset, held back-to-back
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        gnt_log.delete();
        fork
            begin
                for (int i = 0; i < 3; i++) issue(0, 1'b0, 2'b00, 32'(16 * i), 32'h0, 1, $urandom, gl, dl);
                set_req(0, 1'b0);
            end
            begin
                int g1, d1;
                for (int i = 0; i < 3; i++) issue(1, 1'b1, 2'b00, 32'(256 + 16 * i), $urandom, 1, 32'h0, g1, d1);
                set_req(1, 1'b0);
            end
        join
        chk("alt_count", 32'(gnt_log.size()), 32'd6);
        if (gnt_log.size() >= 3) begin
            chk("alt_first", 32'(gnt_log[0]), 32'd0);
            chk("alt_second", 32'(gnt_log[1]), 32'd1);
            chk("alt_third", 32'(gnt_log[2]), 32'd0);
        end
        idle(3);

        // Randomized concurrent traffic from both requesters
        fork
            rand_stream(0, 60);
            rand_stream(1, 60);
        join
        idle(3);

        // Reset while BUSY, then a fresh r1 access
        drive_payload(0, 1'b0, 2'b00, 32'h40, 32'h0);
        r0_req = 1'b1;
        idle(4);
        chk("busy_before_reset", 32'(m_req), 32'h1);
        reset = 1'b0;
        r0_req = 1'b0;
        idle(1);
        check_reset_outputs("mid_reset");
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("no_done_after_reset", 32'({r0_done, r1_done}), 32'h0);
        end
        issue(1, 1'b0, 2'b10, 32'h41, 32'h0, 1, 32'h1234_5678, gl, dl);
        chk("post_reset_gnt_lat", 32'(gl), 32'd1);
        chk("post_reset_done_lat", 32'(dl), 32'd3);
        chk("post_reset_rdata", r1_rdata, 32'h0000_0056);
        set_req(1, 1'b0);
        idle(3);

        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q1_drained", 32'(q1.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
